mcu_sdram_bridge: RTL and testbench

MCU_SDRAM_BRIDGE -- requirements
Module: mcu_sdram_bridge

---
 rtl/mcu_sdram_bridge.sv | 196 +++++++++++++++++++
 tb/tb_mcu_sdram_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_sdram_bridge.sv
// 32-bit MCU word port to a 16-bit SDRAM slave: each word access is split into two halfword phases.
// Optional build macro MCU_SDRAM_SKIP_EMPTY_HALF_EN skips write halfwords whose byte enables are all zero.
module mcu_sdram_bridge #(
  parameter int MEM_ADDR_BITS = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MEM_ADDR_BITS-1:0] mem_addr,
  input  logic                     mem_read_en,
  input  logic                     mem_write_en,
  input  logic [3:0]               mem_byte_enable,
  input  logic [31:0]              mem_write_data,
  output logic [31:0]              mem_read_data,
  output logic                     mem_ack,
  output logic                     busy,
  output logic [MEM_ADDR_BITS:0]   sdram_slave_address,
  output logic [1:0]               sdram_slave_byteenable_n,
  output logic                     sdram_slave_chipselect,
  output logic [15:0]              sdram_slave_writedata,
  output logic                     sdram_slave_read_n,
  output logic                     sdram_slave_write_n,
  input  logic [15:0]              sdram_slave_readdata,
  input  logic                     sdram_slave_waitrequest,
  input  logic                     sdram_slave_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LO   = 3'd1,
    WR_HI   = 3'd2,
    RD_LO   = 3'd3,
    RD_HI   = 3'd4,
    RD_WAIT = 3'd5,
    ACK     = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               be_q, be_d;
  logic [1:0]               beat_q, beat_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic [MEM_ADDR_BITS:0]   sa_q, sa_d;
  logic [1:0]               sbe_q, sbe_d;
  logic                     cs_q, cs_d;
  logic [15:0]              swd_q, swd_d;
  logic                     rdn_q, rdn_d;
  logic                     wrn_q, wrn_d;
  logic                     beat_in;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    beat_d  = beat_q;
    rdata_d = rdata_q;

    // Read beats are accepted in any read phase, including the one in which the issue advances.
    beat_in = sdram_slave_readdatavalid &&
              (state_q == RD_LO || state_q == RD_HI || state_q == RD_WAIT);
    if (beat_in) begin
      if (beat_q == 2'd0) rdata_d[15:0]  = sdram_slave_readdata;
      else                rdata_d[31:16] = sdram_slave_readdata;
      beat_d = beat_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (mem_write_en || mem_read_en) begin
          addr_d  = mem_addr;
          wdata_d = mem_write_data;
          be_d    = mem_byte_enable;
          if (mem_write_en) begin
`ifdef MCU_SDRAM_SKIP_EMPTY_HALF_EN
            if (mem_byte_enable[1:0] != 2'b00)      state_d = WR_LO;
            else if (mem_byte_enable[3:2] != 2'b00) state_d = WR_HI;
            else                                    state_d = ACK;
`else
            state_d = WR_LO;
`endif
          end else begin
            beat_d  = 2'd0;
            state_d = RD_LO;
          end
        end
      end
      WR_LO: begin
        if (!sdram_slave_waitrequest) begin
`ifdef MCU_SDRAM_SKIP_EMPTY_HALF_EN
          state_d = (be_q[3:2] == 2'b00) ? ACK : WR_HI;
`else
          state_d = WR_HI;
`endif
        end
      end
      WR_HI:   if (!sdram_slave_waitrequest) state_d = ACK;
      RD_LO:   if (!sdram_slave_waitrequest) state_d = RD_HI;
      RD_HI:   if (!sdram_slave_waitrequest) state_d = RD_WAIT;
      RD_WAIT: state_d = RD_WAIT;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (beat_in && beat_q == 2'd1) state_d = ACK;

    // Slave outputs are registered, so they are derived from the state being entered.
    sa_d  = sa_q;
    swd_d = swd_q;
    sbe_d = sbe_q;
    cs_d  = 1'b0;
    rdn_d = 1'b1;
    wrn_d = 1'b1;
    case (state_d)
      WR_LO: begin
        sa_d  = {addr_d, 1'b0};
        swd_d = wdata_d[15:0];
        sbe_d = ~be_d[1:0];
        cs_d  = 1'b1;
        wrn_d = 1'b0;
      end
      WR_HI: begin
        sa_d  = {addr_d, 1'b1};
        swd_d = wdata_d[31:16];
        sbe_d = ~be_d[3:2];
        cs_d  = 1'b1;
        wrn_d = 1'b0;
      end
      RD_LO: begin
        sa_d  = {addr_d, 1'b0};
        sbe_d = 2'b00;
        cs_d  = 1'b1;
        rdn_d = 1'b0;
      end
      RD_HI: begin
        sa_d  = {addr_d, 1'b1};
        sbe_d = 2'b00;
        cs_d  = 1'b1;
        rdn_d = 1'b0;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase

    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      beat_q  <= 2'd0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      sa_q    <= '0;
      sbe_q   <= 2'b11;
      cs_q    <= 1'b0;
      swd_q   <= '0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      sa_q    <= sa_d;
      sbe_q   <= sbe_d;
      cs_q    <= cs_d;
      swd_q   <= swd_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
    end
  end

  assign mem_read_data            = rdata_q;
  assign mem_ack                  = ack_q;
  assign busy                     = busy_q;
  assign sdram_slave_address      = sa_q;
  assign sdram_slave_byteenable_n = sbe_q;
  assign sdram_slave_chipselect   = cs_q;
  assign sdram_slave_writedata    = swd_q;
  assign sdram_slave_read_n       = rdn_q;
  assign sdram_slave_write_n      = wrn_q;

endmodule

// File: tb/tb_mcu_sdram_bridge.sv
// Scoreboard bench for mcu_sdram_bridge: stimulus queues expected slave cycles and acks,
// a negedge monitor models the slave and pops/compares as the bridge presents them.
module tb_mcu_sdram_bridge;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en, mem_write_en;
  logic [3:0]    mem_byte_enable;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic          mem_ack, busy;
  logic [AW:0]   sa;
  logic [1:0]    sben;
  logic          cs;
  logic [15:0]   swd;
  logic          rdn, wrn;
  logic [15:0]   srd;
  logic          swait, srvalid;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acks = 0;
  int ack_mark = 0;
  int stall_left = 0;
  int beat_extra_hi = 0;
  int req_edge = 0;

  typedef struct { logic [AW:0] a; logic [15:0] d; logic [1:0] ben; } wr_t;
  typedef struct { int due; logic [15:0] d; } beat_t;
  typedef struct { int lat; logic [31:0] rd; } ack_t;

  wr_t         exp_wr[$];
  logic [AW:0] exp_ra[$];
  logic [15:0] beat_src[$];
  beat_t       pend[$];
  ack_t        exp_ack[$];

  mcu_sdram_bridge #(.MEM_ADDR_BITS(AW)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .mem_addr                  (mem_addr),
    .mem_read_en               (mem_read_en),
    .mem_write_en              (mem_write_en),
    .mem_byte_enable           (mem_byte_enable),
    .mem_write_data            (mem_write_data),
    .mem_read_data             (mem_read_data),
    .mem_ack                   (mem_ack),
    .busy                      (busy),
    .sdram_slave_address       (sa),
    .sdram_slave_byteenable_n  (sben),
    .sdram_slave_chipselect    (cs),
    .sdram_slave_writedata     (swd),
    .sdram_slave_read_n        (rdn),
    .sdram_slave_write_n       (wrn),
    .sdram_slave_readdata      (srd),
    .sdram_slave_waitrequest   (swait),
    .sdram_slave_readdatavalid (srvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and scoreboard monitor; outputs sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [42:0] prev_bus;
  initial begin swait = 1'b0; srvalid = 1'b0; srd = 16'h0; end

  always @(negedge clk) begin : mon
    wr_t         w;
    ack_t        k;
    beat_t       b;
    logic [AW:0] ra;
    logic        stall_now;
    logic [42:0] bus_now;
    bus_now = {sa, swd, sben, cs, rdn, wrn};
    if (prev_stall) begin
      checks++;
      if (bus_now !== prev_bus) begin
        errors++;
        $display("FAIL stall_hold got %h want %h", bus_now, prev_bus);
      end
    end
    stall_now = cs && (stall_left > 0);
    if (stall_now) stall_left--;
    swait = stall_now;
    prev_stall = stall_now;
    prev_bus = bus_now;

    if (cs && !wrn && !stall_now) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr %h data %h ben %b want none", sa, swd, sben);
      end else begin
        w = exp_wr.pop_front();
        if (sa !== w.a || swd !== w.d || sben !== w.ben) begin
          errors++;
          $display("FAIL wr_cycle got %h/%h/%b want %h/%h/%b", sa, swd, sben, w.a, w.d, w.ben);
        end
      end
    end

    if (cs && !rdn && !stall_now) begin
      checks++;
      if (exp_ra.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got addr %h want none", sa);
      end else begin
        ra = exp_ra.pop_front();
        if (sa !== ra || sben !== 2'b00) begin
          errors++;
          $display("FAIL rd_cycle got %h/%b want %h/00", sa, sben, ra);
        end
      end
      b.due = cyc + 2 + (sa[0] ? beat_extra_hi : 0);
      b.d = (beat_src.size() != 0) ? beat_src.pop_front() : 16'h0;
      pend.push_back(b);
    end

    srvalid = 1'b0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      b = pend.pop_front();
      srvalid = 1'b1;
      srd = b.d;
    end

    if (mem_ack === 1'b1) begin
      acks++;
      checks++;
      if (exp_ack.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got 1 want 0 at cycle %0d", cyc);
      end else begin
        k = exp_ack.pop_front();
        if (mem_read_data !== k.rd || (cyc + 1 - req_edge) != k.lat) begin
          errors++;
          $display("FAIL ack_resp got rd %h lat %0d want rd %h lat %0d",
                   mem_read_data, cyc + 1 - req_edge, k.rd, k.lat);
        end
      end
    end
  end

  task automatic push_wr(input logic [AW:0] a, input logic [15:0] d, input logic [1:0] ben);
    wr_t w;
    w.a = a; w.d = d; w.ben = ben;
    exp_wr.push_back(w);
  endtask

  task automatic push_ack(input int lat, input logic [31:0] rd);
    ack_t k;
    k.lat = lat; k.rd = rd;
    exp_ack.push_back(k);
  endtask

  // Called at a negedge; request is sampled at the following posedge.
  task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic we, input logic re, input int stall);
    ack_mark = acks;
    mem_addr = a; mem_write_data = d; mem_byte_enable = be;
    mem_write_en = we; mem_read_en = re;
    stall_left = stall;
    req_edge = cyc + 1;
    @(negedge clk);
    mem_write_en = 1'b0; mem_read_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_req got %b want 1", busy);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    while (acks == ack_mark && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (acks == ack_mark) begin
      errors++;
      $display("FAIL ack_timeout got none want ack within 60 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    logic [58:0] got, want;
    got  = {mem_ack, mem_read_data, busy, sa, sben, cs, rdn, wrn};
    want = {1'b0, 32'h0, 1'b0, {(AW+1){1'b0}}, 2'b11, 1'b0, 1'b1, 1'b1};
    checks++;
    if (got !== want || swd !== 16'h0) begin
      errors++;
      $display("FAIL %s got %h/%h want %h/0000", tag, got, swd, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    mem_byte_enable = 4'h0; mem_write_data = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset("reset_init");
    reset = 1'b0;
    @(negedge clk);

    // Full-word write, no stalls.
    push_wr(22'h00020, 16'hBEEF, 2'b00);
    push_wr(22'h00021, 16'hDEAD, 2'b00);
    push_ack(3, 32'h0);
    send(21'h00010, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 0);
    wait_ack();

    // Read with beats two cycles after each issue.
    exp_ra.push_back(22'h0000A);
    exp_ra.push_back(22'h0000B);
    beat_src.push_back(16'h5678);
    beat_src.push_back(16'h1234);
    push_ack(5, 32'h12345678);
    send(21'h00005, 32'h0, 4'b0000, 1'b0, 1'b1, 0);
    wait_ack();

    // Three stall cycles in the low phase.
    push_wr(22'h3579A, 16'hF00D, 2'b00);
    push_wr(22'h3579B, 16'hCAFE, 2'b00);
    push_ack(6, 32'h12345678);
    send(21'h1ABCD, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, 3);
    wait_ack();

    // Empty low half, then fully empty, then empty high half.
`ifdef MCU_SDRAM_SKIP_EMPTY_HALF_EN
    push_wr(22'h00201, 16'h1122, 2'b00);
    push_ack(2, 32'h12345678);
`else
    push_wr(22'h00200, 16'h3344, 2'b11);
    push_wr(22'h00201, 16'h1122, 2'b00);
    push_ack(3, 32'h12345678);
`endif
    send(21'h00100, 32'h11223344, 4'b1100, 1'b1, 1'b0, 0);
    wait_ack();

`ifdef MCU_SDRAM_SKIP_EMPTY_HALF_EN
    push_ack(1, 32'h12345678);
`else
    push_wr(22'h0000E, 16'h5A5A, 2'b11);
    push_wr(22'h0000F, 16'hA5A5, 2'b11);
    push_ack(3, 32'h12345678);
`endif
    send(21'h00007, 32'hA5A55A5A, 4'b0000, 1'b1, 1'b0, 0);
    wait_ack();

`ifdef MCU_SDRAM_SKIP_EMPTY_HALF_EN
    push_wr(22'h00080, 16'hBEAD, 2'b00);
    push_ack(2, 32'h12345678);
`else
    push_wr(22'h00080, 16'hBEAD, 2'b00);
    push_wr(22'h00081, 16'h0000, 2'b11);
    push_ack(3, 32'h12345678);
`endif
    send(21'h00040, 32'h0000BEAD, 4'b0011, 1'b1, 1'b0, 0);
    wait_ack();

    // Simultaneous read and write: write wins.
    push_wr(22'h00044, 16'h0304, 2'b00);
    push_wr(22'h00045, 16'h0102, 2'b00);
    push_ack(3, 32'h12345678);
    send(21'h00022, 32'h01020304, 4'b1111, 1'b1, 1'b1, 0);
    wait_ack();

    // Read pulse while busy is dropped; new address must not leak into the write.
    push_wr(22'h00066, 16'h0C0D, 2'b00);
    push_wr(22'h00067, 16'h0A0B, 2'b00);
    push_ack(3, 32'h12345678);
    send(21'h00033, 32'h0A0B0C0D, 4'b1111, 1'b1, 1'b0, 0);
    mem_addr = 21'h00099;
    mem_read_en = 1'b1;
    @(negedge clk);
    mem_read_en = 1'b0;
    wait_ack();

    // Reset in RD_WAIT after one beat; late beat must be ignored.
    exp_ra.push_back(22'h3FFFFE);
    exp_ra.push_back(22'h3FFFFF);
    beat_src.push_back(16'hAAAA);
    beat_src.push_back(16'hBBBB);
    beat_extra_hi = 5;
    send(21'h1FFFFF, 32'h0, 4'b0000, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset("reset_mid_read");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    beat_extra_hi = 0;
    chk_reset("late_beat_ignored");

    // Next read returns correct data.
    exp_ra.push_back(22'h00006);
    exp_ra.push_back(22'h00007);
    beat_src.push_back(16'h9ABC);
    beat_src.push_back(16'hDEF0);
    push_ack(5, 32'hDEF09ABC);
    send(21'h00003, 32'h0, 4'b0000, 1'b0, 1'b1, 0);
    wait_ack();

    repeat (5) @(negedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_ra.size() != 0 || exp_ack.size() != 0 || pend.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got wr %0d rd %0d ack %0d beats %0d want all 0",
               exp_wr.size(), exp_ra.size(), exp_ack.size(), pend.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
